// File: rtl/image_read_ctrl.sv
// Streams a bottom-up, byte-interleaved RGB frame out of a synchronous-read memory
// as top-to-bottom raster pixels on a valid/ready interface.
module image_read_ctrl #(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512,
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              line_last,
    output logic              frame_last
);

    localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(3 * WIDTH);
    localparam logic [ADDR_W-1:0] TOP_BASE  = ADDR_W'(3 * WIDTH * (HEIGHT - 1));
    localparam logic [ADDR_W-1:0] PIX_BYTES = ADDR_W'(3);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH0 = 3'd1;
    localparam logic [2:0] S_FETCH1 = 3'd2;
    localparam logic [2:0] S_FETCH2 = 3'd3;
    localparam logic [2:0] S_CAPB   = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]        r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_col_off;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [7:0]        r_r;
    logic [7:0]        r_g;
    logic [7:0]        r_b;
    logic              r_line_last;
    logic              r_frame_last;

    logic [2:0]        w_state_n;
    logic [X_W-1:0]    w_x_n;
    logic [Y_W-1:0]    w_y_n;
    logic [ADDR_W-1:0] w_base_n;
    logic [ADDR_W-1:0] w_col_n;
    logic              w_done_n;
    logic              w_last_x;
    logic              w_last_y;
    logic              w_fetch_n;
    logic [ADDR_W-1:0] w_fetch_addr;

    assign w_last_x     = (r_x == X_LAST);
    assign w_last_y     = (r_y == Y_LAST);
    assign w_fetch_n    = (w_state_n == S_FETCH0) || (w_state_n == S_FETCH1) ||
                          (w_state_n == S_FETCH2);
    assign w_fetch_addr = w_base_n + w_col_n;

    // Next-state, position counters and frame-end detection
    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_base_n  = r_row_base;
        w_col_n   = r_col_off;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_n = S_FETCH0;
            S_FETCH0: w_state_n = S_FETCH1;
            S_FETCH1: w_state_n = S_FETCH2;
            S_FETCH2: w_state_n = S_CAPB;
            S_CAPB:   w_state_n = S_OUT;
            S_OUT: begin
                if (pix_ready) begin
                    if (w_last_x && w_last_y) begin
                        w_state_n = S_IDLE;
                        w_x_n     = '0;
                        w_y_n     = '0;
                        w_base_n  = TOP_BASE;
                        w_col_n   = '0;
                        w_done_n  = 1'b1;
                    end else if (w_last_x) begin
                        w_state_n = S_FETCH0;
                        w_x_n     = '0;
                        w_y_n     = r_y + Y_W'(1);
                        w_base_n  = r_row_base - ROW_BYTES;
                        w_col_n   = '0;
                    end else begin
                        w_state_n = S_FETCH0;
                        w_x_n     = r_x + X_W'(1);
                        w_col_n   = r_col_off + PIX_BYTES;
                    end
                end
            end
            default:  w_state_n = S_IDLE;
        endcase
        // Abort wins over everything, including a coincident last-pixel handshake
        if (abort && (r_state != S_IDLE)) begin
            w_state_n = S_IDLE;
            w_x_n     = '0;
            w_y_n     = '0;
            w_base_n  = TOP_BASE;
            w_col_n   = '0;
            w_done_n  = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_row_base   <= TOP_BASE;
            r_col_off    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_valid      <= 1'b0;
            r_r          <= '0;
            r_g          <= '0;
            r_b          <= '0;
            r_line_last  <= 1'b0;
            r_frame_last <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_x          <= w_x_n;
            r_y          <= w_y_n;
            r_row_base   <= w_base_n;
            r_col_off    <= w_col_n;
            r_busy       <= (w_state_n != S_IDLE);
            r_done       <= w_done_n;
            r_rd_en      <= w_fetch_n;
            if (w_state_n == S_FETCH0) begin
                r_addr <= w_fetch_addr;
            end else if (w_fetch_n) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            // Read data lands one cycle after each strobe
            if (r_state == S_FETCH1) r_r <= mem_rdata;
            if (r_state == S_FETCH2) r_g <= mem_rdata;
            if (r_state == S_CAPB)   r_b <= mem_rdata;
            r_valid      <= (w_state_n == S_OUT);
            r_line_last  <= (w_state_n == S_OUT) && w_last_x;
            r_frame_last <= (w_state_n == S_OUT) && w_last_x && w_last_y;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign pix_valid  = r_valid;
    assign pix_r      = r_r;
    assign pix_g      = r_g;
    assign pix_b      = r_b;
    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign line_last  = r_line_last;
    assign frame_last = r_frame_last;

endmodule

// File: doc/image_read_ctrl.md
Name: image_read_ctrl

Overview:
- Sequencer that streams an interleaved 8-bit RGB image out of a byte-wide, synchronous-read frame memory, one pixel at a time, in top-to-bottom raster order.
- The memory holds rows bottom-up, 3 bytes per pixel: byte 0 = R, byte 1 = G, byte 2 = B.
- The block generates all memory addresses, de-interleaves the three bytes into R/G/B, and presents each pixel on a valid/ready stream for the downstream processing stages.

Parameters:
- WIDTH, 768, pixels per row (>=1).
- HEIGHT, 512, rows per frame (>=1).
- ADDR_W, 21, memory address width; must satisfy 2^ADDR_W >= 3*WIDTH*HEIGHT.
- X_W, 10, width of pix_x; must satisfy 2^X_W >= WIDTH.
- Y_W, 10, width of pix_y; must satisfy 2^Y_W >= HEIGHT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last pixel handshake.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_rdata  in  8  read data, valid exactly 1 cycle after the mem_rd_en cycle.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts the pixel.
- pix_r / pix_g / pix_b  out  8 each  pixel components.
- pix_x  out  X_W  column index, 0..WIDTH-1.
- pix_y  out  Y_W  row index, 0 = top row.
- line_last  out  1  pix_x == WIDTH-1; qualified by pix_valid.
- frame_last  out  1  last pixel of the frame; qualified by pix_valid.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - State = IDLE; x = 0, y = 0, row_base = 3*WIDTH*(HEIGHT-1).
  - Asserting rst mid-frame discards the frame; no done pulse.
- Address rule: mem_addr = row_base + 3*x + c, where c = 0 (R), 1 (G), 2 (B).
  - row_base starts at 3*WIDTH*(HEIGHT-1).
  - row_base decreases by 3*WIDTH at each row end.
  - Use a running column offset (+3 per pixel). No multipliers.
- FSM states: IDLE, FETCH0, FETCH1, FETCH2, CAPB, OUT.
  - IDLE: if start=1, go to FETCH0; x, y and row_base are already at their reset values.
  - FETCH0: mem_rd_en=1, c=0 -> FETCH1.
  - FETCH1: mem_rd_en=1, c=1; capture mem_rdata into R -> FETCH2.
  - FETCH2: mem_rd_en=1, c=2; capture mem_rdata into G -> CAPB.
  - CAPB: mem_rd_en=0; capture mem_rdata into B -> OUT.
  - OUT: pix_valid=1; pix_* and the position outputs are held stable until pix_ready=1.
- On a handshake in OUT:
  - If frame_last: go to IDLE, pulse done in the next cycle, reset x, y and row_base.
  - Else if line_last: x = 0, y = y+1, row_base -= 3*WIDTH, go to FETCH0.
  - Else: x = x+1, go to FETCH0.
- Timing:
  - Latency from start (sampled in cycle 0) to first pix_valid is cycle 5.
  - Throughput with pix_ready tied high is 1 pixel per 5 cycles.
  - pix_valid never depends combinationally on pix_ready.
- mem_rd_en and mem_addr are registered outputs. mem_addr holds its last value when mem_rd_en = 0.
- start while busy is ignored.
- A start in the same cycle that done is high is accepted. That cycle is IDLE, so the next frame begins immediately.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, pix_valid=0, counters reset, no done.
  - abort overrides a coincident handshake.
  - abort in IDLE has no effect.
- Degenerate frame, WIDTH=1: line_last is set on every pixel.
- Degenerate frame, WIDTH=HEIGHT=1: a single pixel is emitted at address 0..2.

Test Plan:
- Basic frame. Setup: WIDTH=4, HEIGHT=2; memory byte[i] = i; pix_ready=1; pulse start.
  - First pixel: addresses 12, 13, 14; R/G/B = 12/13/14; pix_x=0, pix_y=0; pix_valid first high 5 cycles after start.
  - Eighth pixel: addresses 9/10/11 with frame_last=1.
  - done pulses once, then busy=0.
- Backpressure: hold pix_ready=0 for 7 cycles on pixel (2,0).
  - Outputs stay stable (R=18); no new mem_rd_en; resumes after ready.
  - Total pixel count is still 8.
- Row wrap: at pixel (3,0), line_last=1 and frame_last=0.
  - Next fetch addresses are 0, 1, 2; pix_y=1.
- Abort: assert abort during FETCH1 of pixel 3.
  - busy=0 next cycle; no done; a new start restarts at addresses 12, 13, 14.
- Async reset mid-OUT: assert rst between clock edges.
  - pix_valid, busy and mem_rd_en drop immediately; no done.
- Start handling:
  - start held high throughout a frame: it has no effect while busy.
  - start asserted in the done cycle: the next frame's FETCH0 follows in the following cycle at address 12.
